// File: rtl/factorial_seq_engine.sv
// factorial_seq_engine: multi-cycle n! unit with valid/ready handshakes on
// both sides. It performs one multiply per clock and flags overflow.
// Optional feature macro: FACT_SAT_EN. When it is defined, the result
// saturates to all ones and the run ends early on the first overflowing
// multiply. When it is undefined, the result wraps mod 2^WIDTH.
module factorial_seq_engine #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_WIDTH-1:0] n,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               overflow,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_WIDTH-1:0] n_q, n_d;
  // i is one bit wider than n so that n = 2^N_WIDTH-1 still terminates
  logic [N_WIDTH:0]   i_q, i_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [2*WIDTH-1:0] prod_s;
  logic               prod_ovf_s;
  logic               run_end_s;

  // Full-width product of the accumulator and the counter, plus the end-of-run test
  always_comb begin
    prod_s     = {{WIDTH{1'b0}}, acc_q} * {{(2*WIDTH-N_WIDTH-1){1'b0}}, i_q};
    prod_ovf_s = |prod_s[2*WIDTH-1:WIDTH];
`ifdef FACT_SAT_EN
    // a saturated accumulator cannot change any more, so stop right away
    run_end_s  = (i_q > {1'b0, n_q}) || ovf_q;
`else
    run_end_s  = (i_q > {1'b0, n_q});
`endif
  end

  // Next-state and next-output logic for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    i_d         = i_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d    = S_RUN;
          n_d        = n;
          acc_d      = WIDTH'(1);
          i_d        = (N_WIDTH+1)'(2);
          ovf_d      = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (run_end_s) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = acc_q;
          overflow_d  = ovf_q;
        end else begin
          i_d = i_q + (N_WIDTH+1)'(1);
`ifdef FACT_SAT_EN
          if (prod_ovf_s) begin
            acc_d = {WIDTH{1'b1}};
            ovf_d = 1'b1;
          end else begin
            acc_d = prod_s[WIDTH-1:0];
          end
`else
          acc_d = prod_s[WIDTH-1:0];
          ovf_d = ovf_q | prod_ovf_s;
`endif
        end
      end
      S_DONE: begin
        // in_ready returns only with IDLE, so no accept can share this edge
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= {N_WIDTH{1'b0}};
      i_q         <= {(N_WIDTH+1){1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      ovf_q       <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      i_q         <= i_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_factorial_seq_engine.sv
// Self-checking bench for factorial_seq_engine (32-bit and 64-bit instances).
module tb_factorial_seq_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  n;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        busy;

  logic        in_valid64;
  logic        in_ready64;
  logic [7:0]  n64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] result64;
  logic        overflow64;
  logic        busy64;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  typedef struct {
    logic [7:0]  n;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  factorial_seq_engine #(.WIDTH(32), .N_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .n(n),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .busy(busy)
  );

  factorial_seq_engine #(.WIDTH(64), .N_WIDTH(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .n(n64),
    .out_valid(out_valid64), .out_ready(out_ready64), .result(result64),
    .overflow(overflow64), .busy(busy64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: wrapped product plus an exact overflow test against 2^32-1
  function automatic exp_t model(input int nv);
    exp_t e;
    longint unsigned t;
    logic [31:0] w;
    int k1;
    w = 32'd1; t = 64'd1; e.ovf = 1'b0; k1 = 0;
    for (int k = 2; k <= nv; k++) begin
      w = w * 32'(k);
      if (!e.ovf) begin
        t = t * 64'(k);
        if (t > 64'h0000_0000_FFFF_FFFF) begin
          e.ovf = 1'b1;
          k1 = k;
        end
      end
    end
    e.res = w;
    e.lat = (nv < 1) ? 1 : nv;
`ifdef FACT_SAT_EN
    if (e.ovf) begin
      e.res = 32'hFFFF_FFFF;
      e.lat = k1;
    end
`endif
    return e;
  endfunction

  // Called #1 after a rising edge; waits for in_ready, presents n for one accept edge.
  task automatic issue(input logic [7:0] nv, input logic [31:0] res, input logic ovf, input int lat);
    exp_t e;
    int g;
    g = 0;
    while (!in_ready && g < 1000) begin @(posedge clk); #1; g++; end
    if (g >= 1000) chk("issue_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    n = nv;
    e.res = res; e.ovf = ovf; e.lat = lat;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 8'($urandom);
  endtask

  // Waits for out_valid, compares against the scoreboard head, then handshakes.
  task automatic collect(input string tag);
    exp_t e;
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sbq.pop_front();
      if (cyc >= 1000) begin
        chk({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
        chk({tag, "_result"}, 64'(result), 64'(e.res));
        chk({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
        chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
        chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
      end
    end
    @(posedge clk); #1;
    chk({tag, "_out_valid_clr"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    exp_t m;
    int cyc;
    int nlist[5] = '{3, 20, 34, 100, 255};

    vecs[0] = '{n: 8'd5,  res: 32'd120,        ovf: 1'b0};
    vecs[1] = '{n: 8'd0,  res: 32'd1,          ovf: 1'b0};
    vecs[2] = '{n: 8'd1,  res: 32'd1,          ovf: 1'b0};
    vecs[3] = '{n: 8'd2,  res: 32'd2,          ovf: 1'b0};
    vecs[4] = '{n: 8'd7,  res: 32'd5040,       ovf: 1'b0};
    vecs[5] = '{n: 8'd12, res: 32'd479001600,  ovf: 1'b0};
`ifdef FACT_SAT_EN
    vecs[6] = '{n: 8'd13, res: 32'hFFFF_FFFF,  ovf: 1'b1};
`else
    vecs[6] = '{n: 8'd13, res: 32'd1932053504, ovf: 1'b1};
`endif
    vecs[7] = '{n: 8'd10, res: 32'd3628800,    ovf: 1'b0};

    rst = 1'b1; in_valid = 1'b0; n = 8'd0; out_ready = 1'b1;
    in_valid64 = 1'b0; n64 = 8'd0; out_ready64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      issue(vecs[v].n, vecs[v].res, vecs[v].ovf, (vecs[v].n == 8'd0) ? 1 : int'(vecs[v].n));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'd1);
      collect($sformatf("vec%0d", v));
    end

    // Model-driven operands, including the full-range n=255
    for (int k = 0; k < 5; k++) begin
      m = model(nlist[k]);
      issue(8'(nlist[k]), m.res, m.ovf, m.lat);
      collect($sformatf("mdl_n%0d", nlist[k]));
    end

    // Result held while out_ready is low; new operand ignored until IDLE
    out_ready = 1'b0;
    issue(8'd4, 32'd24, 1'b0, 4);
    cyc = 0;
    while (!out_valid && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    chk("hold_latency", 64'(cyc), 64'd4);
    in_valid = 1'b1; n = 8'd9;
    for (int h = 0; h < 10; h++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", h), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d_result", h), 64'(result), 64'd24);
      chk($sformatf("hold%0d_in_ready", h), 64'(in_ready), 64'd0);
    end
    void'(sbq.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_out_valid", 64'(out_valid), 64'd0);
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    chk("hs_busy", 64'(busy), 64'd0);
    sbq.push_back('{res: 32'd362880, ovf: 1'b0, lat: 9});
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect("after_hold_n9");

    // Reset in the middle of a run discards the operation
    issue(8'd10, 32'd3628800, 1'b0, 10);
    repeat (4) begin @(posedge clk); #1; end
    chk("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    void'(sbq.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    chk("midrst_no_output", 64'(out_valid), 64'd0);
    issue(8'd10, 32'd3628800, 1'b0, 10);
    collect("post_rst_n10");

    // 64-bit instance: n=20 fits, n=255 overflows and terminates
    in_valid64 = 1'b1; n64 = 8'd20;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    cyc = 0;
    while (!out_valid64 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    chk("w64_n20_result", result64, 64'd2432902008176640000);
    chk("w64_n20_ovf", 64'(overflow64), 64'd0);
    chk("w64_n20_latency", 64'(cyc), 64'd20);
    @(posedge clk); #1;
    in_valid64 = 1'b1; n64 = 8'd255;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    cyc = 0;
    while (!out_valid64 && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    chk("w64_n255_done", 64'(out_valid64), 64'd1);
    chk("w64_n255_ovf", 64'(overflow64), 64'd1);
`ifdef FACT_SAT_EN
    chk("w64_n255_result", result64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_n255_latency", 64'(cyc), 64'd21);
`else
    chk("w64_n255_result", result64, 64'd0);
    chk("w64_n255_latency", 64'(cyc), 64'd255);
`endif
    @(posedge clk); #1;
    chk("w64_in_ready_back", 64'(in_ready64), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
